spi_slave_sync: RTL
===================

// Module: spi_slave_sync
// PURPOSE
//  - SPI responder (slave end) for spi_master_rtl frames, fully synchronous to the system clock.
//  - Oversamples i_sclk/i_mosi/i_cs. Deserialises a BITS-bit MOSI frame into o_rx_data.
//  - Serialises a queued response word onto MISO in the same frame.
//  - Front end for the next exe units, so datapath logic no longer runs on the SPI clock.
// PARAMETERS
//  BITS      28   frame length in bits; also the width of the rx/tx words
//  SYNC_FF   2    synchroniser depth on sclk/mosi/cs (>=2)
// PORTS
//  i_clk        in   1     system clock; one clock for the whole block
//  i_rst        in   1     synchronous, active-high reset
//  i_sclk       in   1     SPI clock from master, async; CPOL=0
//  i_mosi       in   1     master-out data, async
//  i_cs         in   1     slave select, async, active-low
//  o_miso       out  1     slave-out data
//  o_rx_data    out  BITS  last complete received frame, MSB first on the wire
//  o_rx_valid   out  1     1-cycle pulse: o_rx_data updated
//  i_tx_data    in   BITS  response word for the next frame
//  i_tx_valid   in   1     response word offered
//  o_tx_ready   out  1     holding register empty; write when i_tx_valid & o_tx_ready
//  o_busy       out  1     frame in progress (state SHIFT)
//  o_frame_err  out  1     1-cycle pulse: cs deasserted with 0 < bit count < BITS
//  o_tx_underrun out 1     1-cycle pulse: frame started with the holding register empty
// BEHAVIOUR
//  - Reset values: o_miso=0, o_rx_data='0, o_rx_valid=0, o_tx_ready=1, o_busy=0,
//    o_frame_err=0, o_tx_underrun=0. Holding register empty, bit count 0, state SYNC_WAIT.
//  - Clock ratio: i_clk >= 4x sclk. Each sclk phase lasts >= 2 i_clk cycles.
//  - Inputs pass through SYNC_FF flops, then a 1-flop edge detector.
//    Edge flags (sclk_rise, sclk_fall, cs_fall, cs_rise) are 1-cycle pulses.
//  - SPI mode 0, MSB first:
//    - MOSI is sampled on sclk_rise.
//    - The tx shift register advances on sclk_fall.
//    - o_miso = tx_shift[BITS-1] while in SHIFT, else 0. MISO is never tri-stated.
//  - FSM:
//    - SYNC_WAIT: entered after reset. Go to IDLE once synced cs==1, so the block never joins
//      a frame mid-stream.
//    - IDLE: on cs_fall, go to SHIFT.
//      - Holding full: tx_shift <= holding, holding emptied (o_tx_ready=1 next cycle).
//      - Holding empty: tx_shift <= '0, o_tx_underrun pulses.
//      - Bit count cleared. o_miso shows the MSB the cycle after cs_fall is detected.
//    - SHIFT:
//      - sclk_rise: rx_shift <= {rx_shift[BITS-2:0], mosi}, count++.
//      - sclk_fall: tx_shift <<= 1.
//      - When count reaches BITS on a sclk_rise: go to DONE.
//      - cs_rise with 0 < count < BITS: o_frame_err, rx discarded, go to IDLE.
//      - cs_rise with count==0: silent return to IDLE.
//    - DONE: o_rx_data <= rx_shift, o_rx_valid=1 for exactly one cycle.
//      - cs already high: go to IDLE.
//      - Otherwise: extra sclk edges are ignored and o_miso=0 until cs_rise, then IDLE.
//  - Latency: o_rx_valid is 1 cycle after the internal sclk_rise of the last bit
//    (SYNC_FF+2 i_clk cycles after the pin edge).
//  - Simultaneous events:
//    - cs_rise in the same cycle as sclk_rise: cs_rise wins and the bit is not sampled.
//    - A tx write in the same cycle as the cs_fall load: the write goes to the now-empty
//      holding register and is used for the following frame.
//  - Holding register: written only when o_tx_ready=1. Writes while full are ignored.
//    Its contents survive frame errors.
//  - Reset mid-frame: all state is cleared and the FSM returns to SYNC_WAIT. The rest of the
//    frame is ignored until cs goes high.
// STRUCTURE
//  - spi_pkg (shared):
//    - localparam SPI_BITS = 28
//    - typedef enum logic [1:0] {SYNC_WAIT, IDLE, SHIFT, DONE} spi_slv_state_t
//    - typedef logic [SPI_BITS-1:0] spi_word_t
//  - Sub-module spi_sync_edge (DEPTH parameter): N-flop synchroniser plus rise/fall pulse
//    outputs. One instance each for sclk, mosi (level only) and cs.
//  - Top level holds the FSM, bit counter ($clog2(BITS+1) bits), rx/tx shift registers and
//    the holding register.
// TESTING
//  - Setup: spi_master_rtl in loopback with this block. i_clk period 20, master sclk >= 4x
//    slower. Check every frame against a scoreboard.
//  1. Load i_tx_data=28'h0ABCDEF. Master sends 28'h1234567. Required:
//     - o_rx_data=28'h1234567 with exactly one o_rx_valid pulse.
//     - Master o_data=28'h0ABCDEF.
//  2. No tx word queued; master sends 28'hFFFFFFF. Required:
//     - o_tx_underrun pulses once.
//     - Master receives 28'h0000000; rx still 28'hFFFFFFF.
//  3. Force cs high after 13 bits. Required:
//     - o_frame_err pulse, no o_rx_valid, o_rx_data unchanged.
//     - Next full frame 28'h5555555 is received correctly.
//  4. Assert i_rst at bit 10 for 1 cycle. Required:
//     - Outputs return to reset values and the remainder of the frame is ignored.
//     - The following frame 28'h2AAAAAA is correct.
//  5. Back-to-back frames, tx words queued one per frame (1..8). Required:
//     - o_tx_ready toggles low/high once per frame.
//     - Master receives 1..8 in order.
//  6. i_tx_valid held while the holding register is full, plus a write on the cs_fall cycle.
//     Required: no word lost or duplicated; the second word is used by the next frame.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the SPI responder: frame length, FSM state encoding, word type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;
   localparam int SPI_BITS = 28;

   typedef enum logic [1:0] {
      SYNC_WAIT,
      IDLE,
      SHIFT,
      DONE
   } spi_slv_state_t;

   typedef logic [SPI_BITS-1:0] spi_word_t;
endpackage

// File: rtl/spi_sync_edge.sv
// Synchroniser for one asynchronous SPI pin, plus rise/fall pulse outputs.
// Latency: DEPTH i_clk cycles from the pin to o_lvl; the edge pulses are combinational on o_lvl.
// Backpressure: none, because the block samples every cycle.
// Ports: i_clk/i_rst (sync, active-high), i_d async pin, o_lvl synced level,
//        o_rise/o_fall are 1-cycle pulses on synced transitions.
module spi_sync_edge #(
   parameter int DEPTH = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_lvl,
   output logic o_rise,
   output logic o_fall
);
   logic [DEPTH-1:0] sync_q;
   logic             prev_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[DEPTH-2:0], i_d};
         prev_q <= sync_q[DEPTH-1];
      end
   end

   assign o_lvl  = sync_q[DEPTH-1];
   assign o_rise = sync_q[DEPTH-1] & ~prev_q;
   assign o_fall = ~sync_q[DEPTH-1] & prev_q;
endmodule

// File: rtl/spi_slave_sync.sv
// SPI mode-0 responder that runs on the system clock. It oversamples sclk/mosi/cs,
//   deserialises a BITS-bit frame and shifts out a queued response word, MSB first.
// Latency: o_rx_valid is 1 cycle after the internal sclk_rise of the last bit (SYNC_FF+2 from the pin).
// Backpressure: a one-deep holding register accepts a write when i_tx_valid & o_tx_ready.
//   A frame that starts while the register is empty sends zeros and pulses o_tx_underrun.
// Ports: i_clk/i_rst (sync, active-high); i_sclk/i_mosi/i_cs async SPI pins; o_miso;
//   o_rx_data/o_rx_valid receive side; i_tx_data/i_tx_valid/o_tx_ready transmit side;
//   o_busy, o_frame_err, o_tx_underrun status.
module spi_slave_sync
   import spi_pkg::*;
#(
   parameter int BITS    = SPI_BITS,
   parameter int SYNC_FF = 2
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_sclk,
   input  logic            i_mosi,
   input  logic            i_cs,
   output logic            o_miso,
   output logic [BITS-1:0] o_rx_data,
   output logic            o_rx_valid,
   input  logic [BITS-1:0] i_tx_data,
   input  logic            i_tx_valid,
   output logic            o_tx_ready,
   output logic            o_busy,
   output logic            o_frame_err,
   output logic            o_tx_underrun
);
   localparam int CW = $clog2(BITS+1);

   logic sclk_lvl_unused, sclk_rise, sclk_fall;
   logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;
   logic cs_lvl, cs_rise, cs_fall;

   spi_sync_edge #(.DEPTH(SYNC_FF)) u_sclk (
      .i_clk(i_clk), .i_rst(i_rst), .i_d(i_sclk),
      .o_lvl(sclk_lvl_unused), .o_rise(sclk_rise), .o_fall(sclk_fall)
   );
   spi_sync_edge #(.DEPTH(SYNC_FF)) u_mosi (
      .i_clk(i_clk), .i_rst(i_rst), .i_d(i_mosi),
      .o_lvl(mosi_lvl), .o_rise(mosi_rise_unused), .o_fall(mosi_fall_unused)
   );
   spi_sync_edge #(.DEPTH(SYNC_FF)) u_cs (
      .i_clk(i_clk), .i_rst(i_rst), .i_d(i_cs),
      .o_lvl(cs_lvl), .o_rise(cs_rise), .o_fall(cs_fall)
   );

   spi_slv_state_t  state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [BITS-1:0] rx_shift_q, rx_shift_d;
   logic [BITS-1:0] tx_shift_q, tx_shift_d;
   logic [BITS-1:0] hold_q, hold_d;
   logic            hold_full_q, hold_full_d;
   logic [BITS-1:0] rx_data_q, rx_data_d;
   logic            rx_valid_q, rx_valid_d;
   logic            frame_err_q, frame_err_d;
   logic            underrun_q, underrun_d;
   logic            tx_wr;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      underrun_d  = 1'b0;

      // A write can only coincide with a cs_fall load when the register is empty.
      // In that case the load takes zeros, and the write is kept for the following frame.
      tx_wr = i_tx_valid & ~hold_full_q;
      if (tx_wr) begin
         hold_d      = i_tx_data;
         hold_full_d = 1'b1;
      end

      case (state_q)
         // Wait for an idle bus so the block never joins a frame that is already in progress.
         SYNC_WAIT: if (cs_lvl) state_d = IDLE;
         IDLE: begin
            if (cs_fall) begin
               state_d = SHIFT;
               cnt_d   = '0;
               if (hold_full_q) begin
                  tx_shift_d  = hold_q;
                  hold_full_d = 1'b0;
               end else begin
                  tx_shift_d = '0;
                  underrun_d = 1'b1;
               end
            end
         end
         SHIFT: begin
            // A cs_rise takes priority over an sclk_rise in the same cycle, so that bit is dropped.
            if (cs_rise) begin
               state_d = IDLE;
               if (cnt_q != '0) frame_err_d = 1'b1;
            end else begin
               if (sclk_rise) begin
                  rx_shift_d = {rx_shift_q[BITS-2:0], mosi_lvl};
                  cnt_d      = cnt_q + CW'(1);
                  if (cnt_q == CW'(BITS-1)) begin
                     state_d    = DONE;
                     rx_data_d  = {rx_shift_q[BITS-2:0], mosi_lvl};
                     rx_valid_d = 1'b1;
                  end
               end
               if (sclk_fall) tx_shift_d = tx_shift_q << 1;
            end
         end
         // Any extra clocks are ignored until the master releases cs.
         DONE: if (cs_lvl) state_d = IDLE;
         default: state_d = SYNC_WAIT;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= SYNC_WAIT;
         cnt_q       <= '0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         underrun_q  <= underrun_d;
      end
   end

   assign o_miso        = (state_q == SHIFT) ? tx_shift_q[BITS-1] : 1'b0;
   assign o_rx_data     = rx_data_q;
   assign o_rx_valid    = rx_valid_q;
   assign o_tx_ready    = ~hold_full_q;
   assign o_busy        = (state_q == SHIFT);
   assign o_frame_err   = frame_err_q;
   assign o_tx_underrun = underrun_q;
endmodule
